reservation_station: RTL and testbench

//  Tomasulo ALU reservation station: holds issued ALU ops until both operands resolve, then dispatches
//  one per cycle to the ALU. Exports busy/ready vectors to RS_chooser; consumes its free_rs_line /
//  exe_rs_line picks. Sits between decoder/ROB issue and the ALU; snoops both CDBs (ALU, LSB).

---
 rtl/reservation_station.sv | 163 ++++++++++++++++
 tb/tb_reservation_station.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// Tomasulo ALU reservation station: buffers issued ops until both operands resolve, then dispatches.
// Optional RS_ISSUE_BYPASS_EN: operands issued while their tag is on a CDB are captured at issue.
module reservation_station #(
   parameter int unsigned RS_SIZE       = 8,
   parameter int unsigned RS_SIZE_WIDTH = 3,
   parameter int unsigned ROB_WIDTH     = 4,
   parameter int unsigned OP_WIDTH      = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     clear,
   input  logic                     inst_valid,
   input  logic [OP_WIDTH-1:0]      inst_op,
   input  logic [31:0]              inst_vj,
   input  logic [31:0]              inst_vk,
   input  logic [ROB_WIDTH-1:0]     inst_qj,
   input  logic [ROB_WIDTH-1:0]     inst_qk,
   input  logic                     inst_qj_has,
   input  logic                     inst_qk_has,
   input  logic [31:0]              inst_imm,
   input  logic [31:0]              inst_pc,
   input  logic [ROB_WIDTH-1:0]     inst_rob_id,
   output logic                     full,
   output logic [RS_SIZE-1:0]       busy,
   output logic [RS_SIZE-1:0]       ready,
   input  logic [RS_SIZE_WIDTH-1:0] free_rs_line,
   input  logic                     has_exe_rs_line,
   input  logic [RS_SIZE_WIDTH-1:0] exe_rs_line,
   input  logic                     cdb_alu_valid,
   input  logic [ROB_WIDTH-1:0]     cdb_alu_rob_id,
   input  logic [31:0]              cdb_alu_value,
   input  logic                     cdb_lsb_valid,
   input  logic [ROB_WIDTH-1:0]     cdb_lsb_rob_id,
   input  logic [31:0]              cdb_lsb_value,
   output logic                     alu_valid,
   output logic [OP_WIDTH-1:0]      alu_op,
   output logic [31:0]              alu_vj,
   output logic [31:0]              alu_vk,
   output logic [31:0]              alu_imm,
   output logic [31:0]              alu_pc,
   output logic [ROB_WIDTH-1:0]     alu_rob_id
);

   logic [RS_SIZE-1:0]   busy_q, qj_has_q, qk_has_q;
   logic [OP_WIDTH-1:0]  op_q     [RS_SIZE];
   logic [31:0]          vj_q     [RS_SIZE];
   logic [31:0]          vk_q     [RS_SIZE];
   logic [31:0]          imm_q    [RS_SIZE];
   logic [31:0]          pc_q     [RS_SIZE];
   logic [ROB_WIDTH-1:0] qj_q     [RS_SIZE];
   logic [ROB_WIDTH-1:0] qk_q     [RS_SIZE];
   logic [ROB_WIDTH-1:0] rob_id_q [RS_SIZE];

   logic        issue;
   logic [31:0] iss_vj, iss_vk;
   logic        iss_qj_has, iss_qk_has;

   assign busy  = busy_q;
   assign ready = busy_q & ~qj_has_q & ~qk_has_q;
   assign full  = &busy_q;
   assign issue = inst_valid & ~full;

   always_comb begin
      iss_vj     = inst_vj;
      iss_vk     = inst_vk;
      iss_qj_has = inst_qj_has;
      iss_qk_has = inst_qk_has;
`ifdef RS_ISSUE_BYPASS_EN
      if (inst_qj_has && cdb_alu_valid && cdb_alu_rob_id == inst_qj) begin
         iss_vj     = cdb_alu_value;
         iss_qj_has = 1'b0;
      end else if (inst_qj_has && cdb_lsb_valid && cdb_lsb_rob_id == inst_qj) begin
         iss_vj     = cdb_lsb_value;
         iss_qj_has = 1'b0;
      end
      if (inst_qk_has && cdb_alu_valid && cdb_alu_rob_id == inst_qk) begin
         iss_vk     = cdb_alu_value;
         iss_qk_has = 1'b0;
      end else if (inst_qk_has && cdb_lsb_valid && cdb_lsb_rob_id == inst_qk) begin
         iss_vk     = cdb_lsb_value;
         iss_qk_has = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q     <= '0;
         qj_has_q   <= '0;
         qk_has_q   <= '0;
         alu_valid  <= 1'b0;
         alu_op     <= '0;
         alu_vj     <= '0;
         alu_vk     <= '0;
         alu_imm    <= '0;
         alu_pc     <= '0;
         alu_rob_id <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            op_q[i]     <= '0;
            vj_q[i]     <= '0;
            vk_q[i]     <= '0;
            imm_q[i]    <= '0;
            pc_q[i]     <= '0;
            qj_q[i]     <= '0;
            qk_q[i]     <= '0;
            rob_id_q[i] <= '0;
         end
      end else if (clear) begin
         busy_q    <= '0;
         alu_valid <= 1'b0;
      end else if (rdy) begin
         // Wakeup: both CDBs snooped in parallel; the ROB keeps their tags distinct.
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && qj_has_q[i]) begin
               if (cdb_alu_valid && cdb_alu_rob_id == qj_q[i]) begin
                  vj_q[i]     <= cdb_alu_value;
                  qj_has_q[i] <= 1'b0;
               end else if (cdb_lsb_valid && cdb_lsb_rob_id == qj_q[i]) begin
                  vj_q[i]     <= cdb_lsb_value;
                  qj_has_q[i] <= 1'b0;
               end
            end
            if (busy_q[i] && qk_has_q[i]) begin
               if (cdb_alu_valid && cdb_alu_rob_id == qk_q[i]) begin
                  vk_q[i]     <= cdb_alu_value;
                  qk_has_q[i] <= 1'b0;
               end else if (cdb_lsb_valid && cdb_lsb_rob_id == qk_q[i]) begin
                  vk_q[i]     <= cdb_lsb_value;
                  qk_has_q[i] <= 1'b0;
               end
            end
         end

         alu_valid <= has_exe_rs_line;
         if (has_exe_rs_line) begin
            alu_op              <= op_q[exe_rs_line];
            alu_vj              <= vj_q[exe_rs_line];
            alu_vk              <= vk_q[exe_rs_line];
            alu_imm             <= imm_q[exe_rs_line];
            alu_pc              <= pc_q[exe_rs_line];
            alu_rob_id          <= rob_id_q[exe_rs_line];
            busy_q[exe_rs_line] <= 1'b0;
         end

         // Issue line is non-busy, so it never collides with the dispatch or a wakeup.
         if (issue) begin
            busy_q[free_rs_line]   <= 1'b1;
            op_q[free_rs_line]     <= inst_op;
            vj_q[free_rs_line]     <= iss_vj;
            vk_q[free_rs_line]     <= iss_vk;
            qj_q[free_rs_line]     <= inst_qj;
            qk_q[free_rs_line]     <= inst_qk;
            qj_has_q[free_rs_line] <= iss_qj_has;
            qk_has_q[free_rs_line] <= iss_qk_has;
            imm_q[free_rs_line]    <= inst_imm;
            pc_q[free_rs_line]     <= inst_pc;
            rob_id_q[free_rs_line] <= inst_rob_id;
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized bench for reservation_station against a per-entry behavioural model.
// Honours RS_ISSUE_BYPASS_EN when defined on the command line.
module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst, rdy, clear, inst_valid;
   logic [5:0]  inst_op;
   logic [31:0] inst_vj, inst_vk, inst_imm, inst_pc;
   logic [3:0]  inst_qj, inst_qk, inst_rob_id;
   logic        inst_qj_has, inst_qk_has;
   logic        full;
   logic [7:0]  busy, ready;
   logic [2:0]  free_rs_line, exe_rs_line;
   logic        has_exe_rs_line;
   logic        cdb_alu_valid, cdb_lsb_valid;
   logic [3:0]  cdb_alu_rob_id, cdb_lsb_rob_id;
   logic [31:0] cdb_alu_value, cdb_lsb_value;
   logic        alu_valid;
   logic [5:0]  alu_op;
   logic [31:0] alu_vj, alu_vk, alu_imm, alu_pc;
   logic [3:0]  alu_rob_id;

   reservation_station dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .inst_valid(inst_valid),
      .inst_op(inst_op), .inst_vj(inst_vj), .inst_vk(inst_vk), .inst_qj(inst_qj),
      .inst_qk(inst_qk), .inst_qj_has(inst_qj_has), .inst_qk_has(inst_qk_has),
      .inst_imm(inst_imm), .inst_pc(inst_pc), .inst_rob_id(inst_rob_id), .full(full),
      .busy(busy), .ready(ready), .free_rs_line(free_rs_line),
      .has_exe_rs_line(has_exe_rs_line), .exe_rs_line(exe_rs_line),
      .cdb_alu_valid(cdb_alu_valid), .cdb_alu_rob_id(cdb_alu_rob_id),
      .cdb_alu_value(cdb_alu_value), .cdb_lsb_valid(cdb_lsb_valid),
      .cdb_lsb_rob_id(cdb_lsb_rob_id), .cdb_lsb_value(cdb_lsb_value),
      .alu_valid(alu_valid), .alu_op(alu_op), .alu_vj(alu_vj), .alu_vk(alu_vk),
      .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_rob_id(alu_rob_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        busy;
      logic [5:0]  op;
      logic [31:0] vj, vk, imm, pc;
      logic [3:0]  qj, qk, rob;
      logic        qjh, qkh;
   } ent_t;

   ent_t m [8];
   ent_t m_alu;
   logic m_alu_valid;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_ready(int i);
      return m[i].busy && !m[i].qjh && !m[i].qkh;
   endfunction

   function automatic logic m_full();
      for (int i = 0; i < 8; i++) if (!m[i].busy) return 1'b0;
      return 1'b1;
   endfunction

   // {hit, value} for a tag against this cycle's CDB broadcasts
   function automatic logic [32:0] cdb_lookup(logic [3:0] tag);
      if (cdb_alu_valid && cdb_alu_rob_id == tag) return {1'b1, cdb_alu_value};
      if (cdb_lsb_valid && cdb_lsb_rob_id == tag) return {1'b1, cdb_lsb_value};
      return '0;
   endfunction

   task automatic check_fields();
      check_eq("alu_op", alu_op, m_alu.op);
      check_eq("alu_vj", alu_vj, m_alu.vj);
      check_eq("alu_vk", alu_vk, m_alu.vk);
      check_eq("alu_imm", alu_imm, m_alu.imm);
      check_eq("alu_pc", alu_pc, m_alu.pc);
      check_eq("alu_rob_id", alu_rob_id, m_alu.rob);
   endtask

   task automatic check_all();
      logic [7:0] eb, er;
      for (int i = 0; i < 8; i++) begin
         eb[i] = m[i].busy;
         er[i] = m_ready(i);
      end
      check_eq("busy", busy, eb);
      check_eq("ready", ready, er);
      check_eq("full", full, &eb);
      check_eq("alu_valid", alu_valid, m_alu_valid);
      if (m_alu_valid) check_fields();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i] = '0;
      m_alu       = '0;
      m_alu_valid = 1'b0;
   endtask

   task automatic idle_inputs();
      rdy = 1'b1; clear = 1'b0; inst_valid = 1'b0; has_exe_rs_line = 1'b0;
      cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0;
      inst_qj_has = 1'b0; inst_qk_has = 1'b0;
   endtask

   // Apply the current inputs for one edge, advance the model, then compare.
   task automatic step();
      ent_t        n [8];
      ent_t        na, e;
      logic        nv;
      logic [32:0] r;
      n  = m;
      na = m_alu;
      nv = m_alu_valid;
      if (clear) begin
         for (int i = 0; i < 8; i++) n[i].busy = 1'b0;
         nv = 1'b0;
      end else if (rdy) begin
         for (int i = 0; i < 8; i++) begin
            if (m[i].busy && m[i].qjh) begin
               r = cdb_lookup(m[i].qj);
               if (r[32]) begin n[i].vj = r[31:0]; n[i].qjh = 1'b0; end
            end
            if (m[i].busy && m[i].qkh) begin
               r = cdb_lookup(m[i].qk);
               if (r[32]) begin n[i].vk = r[31:0]; n[i].qkh = 1'b0; end
            end
         end
         nv = has_exe_rs_line;
         if (has_exe_rs_line) begin
            na = m[exe_rs_line];
            n[exe_rs_line].busy = 1'b0;
         end
         if (inst_valid && !m_full()) begin
            e = '{busy: 1'b1, op: inst_op, vj: inst_vj, vk: inst_vk, imm: inst_imm,
                  pc: inst_pc, qj: inst_qj, qk: inst_qk, rob: inst_rob_id,
                  qjh: inst_qj_has, qkh: inst_qk_has};
`ifdef RS_ISSUE_BYPASS_EN
            r = cdb_lookup(inst_qj);
            if (inst_qj_has && r[32]) begin e.vj = r[31:0]; e.qjh = 1'b0; end
            r = cdb_lookup(inst_qk);
            if (inst_qk_has && r[32]) begin e.vk = r[31:0]; e.qkh = 1'b0; end
`endif
            n[free_rs_line] = e;
         end
      end
      @(posedge clk);
      #1;
      m           = n;
      m_alu       = na;
      m_alu_valid = nv;
      check_all();
   endtask

   task automatic random_inputs(bit fill_phase);
      int         frees[$];
      int         rdys[$];
      logic [3:0] tags[$];
      frees = {}; rdys = {}; tags = {};
      for (int i = 0; i < 8; i++) begin
         if (!m[i].busy) frees.push_back(i);
         if (m_ready(i)) rdys.push_back(i);
         if (m[i].busy && m[i].qjh) tags.push_back(m[i].qj);
         if (m[i].busy && m[i].qkh) tags.push_back(m[i].qk);
      end
      rdy   = ($urandom_range(0, 9) != 0);
      clear = rdy && ($urandom_range(0, 59) == 0);
      inst_valid  = ($urandom_range(0, 3) != 0);
      inst_op     = 6'($urandom);
      inst_vj     = $urandom;
      inst_vk     = $urandom;
      inst_imm    = $urandom;
      inst_pc     = $urandom;
      inst_qj     = 4'($urandom);
      inst_qk     = 4'($urandom);
      inst_rob_id = 4'($urandom);
      inst_qj_has = 1'($urandom);
      inst_qk_has = 1'($urandom);
      free_rs_line = (frees.size() > 0) ? 3'(frees[$urandom_range(0, frees.size() - 1)])
                                        : 3'($urandom);
      has_exe_rs_line = (rdys.size() > 0) && ($urandom_range(0, fill_phase ? 7 : 1) == 0);
      exe_rs_line = (rdys.size() > 0) ? 3'(rdys[$urandom_range(0, rdys.size() - 1)]) : 3'd0;
      cdb_alu_valid  = ($urandom_range(0, fill_phase ? 9 : 1) == 0);
      cdb_lsb_valid  = ($urandom_range(0, fill_phase ? 9 : 2) == 0);
      cdb_alu_value  = $urandom;
      cdb_lsb_value  = $urandom;
      cdb_alu_rob_id = (tags.size() > 0) ? tags[$urandom_range(0, tags.size() - 1)]
                                         : 4'($urandom);
      cdb_lsb_rob_id = (tags.size() > 0) ? tags[$urandom_range(0, tags.size() - 1)]
                                         : 4'($urandom);
      if ($urandom_range(0, 3) == 0) cdb_lsb_rob_id = inst_qj;
      if (cdb_alu_valid && cdb_lsb_valid && cdb_alu_rob_id == cdb_lsb_rob_id)
         cdb_lsb_valid = 1'b0;
   endtask

   task automatic mid_reset();
      #1 rst = 1'b1;
      model_reset();
      #1;
      check_all();
      check_fields();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      free_rs_line = '0; exe_rs_line = '0;
      inst_op = '0; inst_vj = '0; inst_vk = '0; inst_imm = '0; inst_pc = '0;
      inst_qj = '0; inst_qk = '0; inst_rob_id = '0;
      cdb_alu_rob_id = '0; cdb_lsb_rob_id = '0; cdb_alu_value = '0; cdb_lsb_value = '0;
      model_reset();
      #12;
      check_all();
      check_fields();
      rst = 1'b0;
      @(posedge clk); #1;

      for (int c = 0; c < 3000; c++) begin
         random_inputs((c % 400) < 60);
         step();
         if (c == 1500) mid_reset();
      end

      // Ready operands: issue, dispatch next cycle, single-cycle alu_valid pulse
      mid_reset();
      idle_inputs();
      inst_valid = 1'b1; inst_op = 6'd1; inst_vj = 32'd5; inst_vk = 32'd7; inst_rob_id = 4'd3;
      free_rs_line = 3'd0;
      step();
      check_eq("t2_ready0", ready[0], 1'b1);
      idle_inputs();
      has_exe_rs_line = 1'b1; exe_rs_line = 3'd0;
      step();
      check_eq("t2_alu_vj", alu_vj, 32'd5);
      check_eq("t2_alu_vk", alu_vk, 32'd7);
      check_eq("t2_alu_rob", alu_rob_id, 4'd3);
      check_eq("t2_busy0", busy[0], 1'b0);
      idle_inputs();
      step();
      check_eq("t2_pulse_end", alu_valid, 1'b0);

      // Issue with a same-cycle LSB broadcast of the pending tag
      inst_valid = 1'b1; inst_qj_has = 1'b1; inst_qj = 4'd5; inst_vk = 32'd1;
      free_rs_line = 3'd1;
      cdb_lsb_valid = 1'b1; cdb_lsb_rob_id = 4'd5; cdb_lsb_value = 32'hAB;
      step();
`ifdef RS_ISSUE_BYPASS_EN
      check_eq("t6_bypass_ready", ready[1], 1'b1);
`else
      check_eq("t6_no_bypass_ready", ready[1], 1'b0);
`endif
      idle_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
